// File: rtl/wb_result_stage.sv
// Write-back result stage: picks ALU, load or link data, extracts and extends loads
// by byte lane, flags bad loads, and registers everything in one WB pipeline register.
module wb_result_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int BIG_ENDIAN = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_MEM,
    input  logic [DATA_W-1:0] ALU_Result_MEM,
    input  logic [DATA_W-1:0] Read_Data_MEM,
    input  logic [DATA_W-1:0] PC_Plus8_MEM,
    input  logic [1:0]        ResultSel_MEM,
    input  logic [1:0]        LoadSize_MEM,
    input  logic              LoadSigned_MEM,
    input  logic              RegWrite_MEM,
    input  logic [REG_AW-1:0] WriteReg_MEM,
    output logic [DATA_W-1:0] Write_Data_WB,
    output logic [REG_AW-1:0] WriteReg_WB,
    output logic              RegWrite_WB,
    output logic              valid_WB,
    output logic              err_WB
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    generate
        if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
            $error("wb_result_stage: DATA_W must be 32 or 64");
        end
    endgenerate

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_LINK = 2'd2,
        SEL_RSVD = 2'd3
    } result_sel_t;

    // Byte k of the memory word in address order, honouring the configured endianness.
    function automatic logic [7:0] lane_byte(input logic [DATA_W-1:0] word, input int k);
        int idx;
        idx = (BIG_ENDIAN != 0) ? (NB - 1 - k) : k;
        return word[8*idx +: 8];
    endfunction

    function automatic int access_bytes(input logic [1:0] size);
        int n;
        n = 1 << int'(size);
        if (n > NB) n = NB;
        return n;
    endfunction

    function automatic logic is_misaligned(input logic [OFF_W-1:0] off, input logic [1:0] size);
        int mask;
        mask = (1 << int'(size)) - 1;
        return (int'(off) & mask) != 0;
    endfunction

    function automatic logic is_illegal(input logic [1:0] size);
        return (size == 2'd3) && (DATA_W == 32);
    endfunction

    // Assemble the field starting at lane=off, then sign/zero extend above it.
    // A full-width access leaves no bits to extend, so LoadSigned has no effect there.
    function automatic logic [DATA_W-1:0] extract_load(
        input logic [DATA_W-1:0] word,
        input logic [OFF_W-1:0]  off,
        input logic [1:0]        size,
        input logic              sgn
    );
        logic [DATA_W-1:0] field;
        logic              sbit;
        int                n;
        int                lane;
        int                pos;
        field = '0;
        n     = access_bytes(size);
        for (int i = 0; i < NB; i++) begin
            if (i < n) begin
                lane = (int'(off) + i) % NB;
                pos  = (BIG_ENDIAN != 0) ? (n - 1 - i) : i;
                field[8*pos +: 8] = lane_byte(word, lane);
            end
        end
        sbit = field[8*n - 1];
        for (int b = 0; b < DATA_W; b++) begin
            if (b >= 8*n) field[b] = sgn & sbit;
        end
        return field;
    endfunction

    logic [OFF_W-1:0]  byte_off;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] next_data;
    logic              next_err;
    logic              next_we;

    assign byte_off  = ALU_Result_MEM[OFF_W-1:0];
    assign load_data = extract_load(Read_Data_MEM, byte_off, LoadSize_MEM, LoadSigned_MEM);

    always_comb begin
        next_data = '0;
        next_err  = 1'b0;
        case (result_sel_t'(ResultSel_MEM))
            SEL_ALU:  next_data = ALU_Result_MEM;
            SEL_MEM: begin
                if (is_illegal(LoadSize_MEM) || is_misaligned(byte_off, LoadSize_MEM)) begin
                    next_err = 1'b1;
                end else begin
                    next_data = load_data;
                end
            end
            SEL_LINK: next_data = PC_Plus8_MEM;
            default:  next_err  = 1'b1;
        endcase
        next_we = RegWrite_MEM && valid_MEM && (WriteReg_MEM != '0) && !next_err;
    end

    // WB pipeline register: reset and flush clear it, stall holds it, invalid loads a bubble.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            Write_Data_WB <= '0;
            WriteReg_WB   <= '0;
            RegWrite_WB   <= 1'b0;
            valid_WB      <= 1'b0;
            err_WB        <= 1'b0;
        end else if (!stall_i) begin
            if (!valid_MEM) begin
                Write_Data_WB <= '0;
                WriteReg_WB   <= '0;
                RegWrite_WB   <= 1'b0;
                valid_WB      <= 1'b0;
                err_WB        <= 1'b0;
            end else begin
                Write_Data_WB <= next_data;
                WriteReg_WB   <= WriteReg_MEM;
                RegWrite_WB   <= next_we;
                valid_WB      <= 1'b1;
                err_WB        <= next_err;
            end
        end
    end

endmodule

// File: tb/tb_wb_result_stage.sv
// Directed bench for wb_result_stage: little- and big-endian 32-bit instances share stimulus.
module tb_wb_result_stage;

    logic        clk = 1'b0;
    logic        reset, stall_i, flush_i, valid_MEM;
    logic [31:0] ALU_Result_MEM, Read_Data_MEM, PC_Plus8_MEM;
    logic [1:0]  ResultSel_MEM, LoadSize_MEM;
    logic        LoadSigned_MEM, RegWrite_MEM;
    logic [4:0]  WriteReg_MEM;

    logic [31:0] wd_le, wd_be;
    logic [4:0]  wr_le, wr_be;
    logic        we_le, we_be, vld_le, vld_be, err_le, err_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_result_stage #(.DATA_W(32), .REG_AW(5), .BIG_ENDIAN(0)) dut_le (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
        .valid_MEM(valid_MEM), .ALU_Result_MEM(ALU_Result_MEM),
        .Read_Data_MEM(Read_Data_MEM), .PC_Plus8_MEM(PC_Plus8_MEM),
        .ResultSel_MEM(ResultSel_MEM), .LoadSize_MEM(LoadSize_MEM),
        .LoadSigned_MEM(LoadSigned_MEM), .RegWrite_MEM(RegWrite_MEM),
        .WriteReg_MEM(WriteReg_MEM), .Write_Data_WB(wd_le), .WriteReg_WB(wr_le),
        .RegWrite_WB(we_le), .valid_WB(vld_le), .err_WB(err_le)
    );

    wb_result_stage #(.DATA_W(32), .REG_AW(5), .BIG_ENDIAN(1)) dut_be (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
        .valid_MEM(valid_MEM), .ALU_Result_MEM(ALU_Result_MEM),
        .Read_Data_MEM(Read_Data_MEM), .PC_Plus8_MEM(PC_Plus8_MEM),
        .ResultSel_MEM(ResultSel_MEM), .LoadSize_MEM(LoadSize_MEM),
        .LoadSigned_MEM(LoadSigned_MEM), .RegWrite_MEM(RegWrite_MEM),
        .WriteReg_MEM(WriteReg_MEM), .Write_Data_WB(wd_be), .WriteReg_WB(wr_be),
        .RegWrite_WB(we_be), .valid_WB(vld_be), .err_WB(err_be)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs after the falling edge, sample 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] rd, input logic [31:0] pc8, input logic [1:0] sz,
                         input logic sgn, input logic rw, input logic [4:0] wr);
        @(negedge clk);
        valid_MEM = v; ResultSel_MEM = sel; ALU_Result_MEM = alu; Read_Data_MEM = rd;
        PC_Plus8_MEM = pc8; LoadSize_MEM = sz; LoadSigned_MEM = sgn;
        RegWrite_MEM = rw; WriteReg_MEM = wr;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_data"}, wd_le, 0);
        check_val({tag, "_wr"}, wr_le, 0);
        check_val({tag, "_we"}, we_le, 0);
        check_val({tag, "_vld"}, vld_le, 0);
        check_val({tag, "_err"}, err_le, 0);
    endtask

    initial begin
        reset = 1'b1; stall_i = 1'b1; flush_i = 1'b0;
        valid_MEM = 1'b1; ResultSel_MEM = 2'd0; ALU_Result_MEM = 32'hDEADBEEF;
        Read_Data_MEM = 32'h12345678; PC_Plus8_MEM = 32'h100; LoadSize_MEM = 2'd2;
        LoadSigned_MEM = 1'b1; RegWrite_MEM = 1'b1; WriteReg_MEM = 5'd7;
        step();
        step();
        check_all_zero("reset_stall");
        check_val("reset_be_data", wd_be, 0);

        @(negedge clk); reset = 1'b0; stall_i = 1'b0;

        // LB signed, offset 3
        drive(1, 2'd1, 32'h00001003, 32'h80123456, 32'h0, 2'd0, 1, 1, 5'd8);
        step();
        check_val("lb_data", wd_le, 32'hFFFFFF80);
        check_val("lb_we", we_le, 1);
        check_val("lb_err", err_le, 0);
        check_val("lb_wr", wr_le, 8);
        check_val("lb_vld", vld_le, 1);
        check_val("lb_be_data", wd_be, 32'h00000056);

        // LBU offset 3
        drive(1, 2'd1, 32'h00000003, 32'h80123456, 32'h0, 2'd0, 0, 1, 5'd9);
        step();
        check_val("lbu_data", wd_le, 32'h00000080);

        // LHU offset 2
        drive(1, 2'd1, 32'h00000002, 32'hA1B2C3D4, 32'h0, 2'd1, 0, 1, 5'd10);
        step();
        check_val("lhu_le_data", wd_le, 32'h0000A1B2);
        check_val("lhu_be_data", wd_be, 32'h0000C3D4);

        // LH signed offset 0
        drive(1, 2'd1, 32'h00000000, 32'hA1B2C3D4, 32'h0, 2'd1, 1, 1, 5'd10);
        step();
        check_val("lh_le_data", wd_le, 32'hFFFFC3D4);
        check_val("lh_be_data", wd_be, 32'hFFFFA1B2);

        // LW with signed flag set is a plain word
        drive(1, 2'd1, 32'h00000000, 32'h80000001, 32'h0, 2'd2, 1, 1, 5'd11);
        step();
        check_val("lw_le_data", wd_le, 32'h80000001);
        check_val("lw_be_data", wd_be, 32'h80000001);

        // Misaligned LH
        drive(1, 2'd1, 32'h00000001, 32'hA1B2C3D4, 32'h0, 2'd1, 0, 1, 5'd12);
        step();
        check_val("mis_err", err_le, 1);
        check_val("mis_we", we_le, 0);
        check_val("mis_data", wd_le, 0);
        check_val("mis_vld", vld_le, 1);
        check_val("mis_wr", wr_le, 12);

        // Doubleword on a 32-bit datapath is illegal
        drive(1, 2'd1, 32'h00000000, 32'hA1B2C3D4, 32'h0, 2'd3, 0, 1, 5'd13);
        step();
        check_val("ld32_err", err_le, 1);
        check_val("ld32_we", we_le, 0);

        // Reserved select
        drive(1, 2'd3, 32'h00005555, 32'h0, 32'h0, 2'd0, 0, 1, 5'd14);
        step();
        check_val("rsvd_err", err_le, 1);
        check_val("rsvd_data", wd_le, 0);
        check_val("rsvd_we", we_le, 0);

        // Link and $zero
        drive(1, 2'd2, 32'h0, 32'h0, 32'h00400008, 2'd0, 0, 1, 5'd31);
        step();
        check_val("link_data", wd_le, 32'h00400008);
        check_val("link_we", we_le, 1);
        check_val("link_err", err_le, 0);
        drive(1, 2'd2, 32'h0, 32'h0, 32'h00400008, 2'd0, 0, 1, 5'd0);
        step();
        check_val("zero_we", we_le, 0);
        check_val("zero_data", wd_le, 32'h00400008);

        // Hazard control: load, stall 3 cycles with changing inputs, then stall+flush
        drive(1, 2'd0, 32'h00001234, 32'h0, 32'h0, 2'd0, 0, 1, 5'd5);
        step();
        check_val("haz_load", wd_le, 32'h1234);
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'd0, 32'h0000AAA0 + i, 32'h0, 32'h0, 2'd0, 0, 1, 5'd6);
            stall_i = 1'b1;
            step();
            check_val("haz_hold_data", wd_le, 32'h1234);
            check_val("haz_hold_wr", wr_le, 5);
            check_val("haz_hold_we", we_le, 1);
        end
        @(negedge clk); flush_i = 1'b1;
        step();
        check_val("flush_vld", vld_le, 0);
        check_val("flush_we", we_le, 0);
        check_val("flush_data", wd_le, 0);
        @(negedge clk); flush_i = 1'b0; stall_i = 1'b0;

        // Invalid instruction loads a bubble
        drive(0, 2'd0, 32'h00009999, 32'h0, 32'h0, 2'd0, 0, 1, 5'd3);
        step();
        check_all_zero("bubble");

        // Reset during stall discards the held instruction; release loads normally
        drive(1, 2'd0, 32'h00000055, 32'h0, 32'h0, 2'd0, 0, 1, 5'd4);
        step();
        check_val("pre_rst_data", wd_le, 32'h55);
        @(negedge clk); stall_i = 1'b1; reset = 1'b1;
        step();
        check_all_zero("rst_mid_stall");
        drive(1, 2'd0, 32'h00000077, 32'h0, 32'h0, 2'd0, 0, 1, 5'd4);
        reset = 1'b0; stall_i = 1'b0;
        step();
        check_val("post_rst_data", wd_le, 32'h77);
        check_val("post_rst_we", we_le, 1);
        check_val("post_rst_vld", vld_le, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_result_stage.md
WB_RESULT_STAGE -- requirements
Module: wb_result_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk and reset.
REQ-002 Parameter DATA_W, default 32, SHALL set the datapath width; the only legal values are 32 and 64.
REQ-003 Parameter REG_AW, default 5, SHALL set the register-address width.
REQ-004 Parameter BIG_ENDIAN, default 0, SHALL select byte-lane order: 0 = little-endian, 1 = big-endian.
REQ-005 Localparam OFF_W = log2(DATA_W/8) SHALL size the byte offset.
REQ-006 The block SHALL have these ports, one per line (name, direction, width, meaning):
 clk  in  1  clock
 reset  in  1  synchronous active-high reset
 stall_i  in  1  hold the WB register
 flush_i  in  1  insert a bubble
 valid_MEM  in  1  MEM-stage instruction valid
 ALU_Result_MEM  in  DATA_W  ALU result / load address
 Read_Data_MEM  in  DATA_W  raw memory word
 PC_Plus8_MEM  in  DATA_W  link value
 ResultSel_MEM  in  2  0 = ALU, 1 = MEM, 2 = LINK, 3 = reserved
 LoadSize_MEM  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
 LoadSigned_MEM  in  1  1 = sign-extend, 0 = zero-extend
 RegWrite_MEM  in  1  write request
 WriteReg_MEM  in  REG_AW  destination register
 Write_Data_WB  out  DATA_W  registered write-back data
 WriteReg_WB  out  REG_AW  registered destination
 RegWrite_WB  out  1  registered qualified write enable
 valid_WB  out  1  WB-stage instruction valid
 err_WB  out  1  misaligned-load / illegal-select flag

Function
REQ-007 All outputs SHALL be registered, with exactly one cycle of latency from the MEM inputs.
REQ-008 Per-edge priority SHALL be: reset > flush_i > stall_i > load.
REQ-009 On flush_i=1, valid_WB, RegWrite_WB and err_WB SHALL go to 0; Write_Data_WB and WriteReg_WB SHALL go to 0. This applies even when stall_i=1 in the same cycle.
REQ-010 On stall_i=1 with flush_i=0, every output SHALL hold its value.
REQ-011 On load with valid_MEM=0, the block SHALL load a bubble with the same values as REQ-009.
REQ-012 The byte offset SHALL be ALU_Result_MEM[OFF_W-1:0].
REQ-013 Lane k (byte) SHALL be Read_Data_MEM[8k+7:8k] when BIG_ENDIAN=0, and byte (DATA_W/8-1-k) when BIG_ENDIAN=1.
REQ-014 Load extraction SHALL select the 8/16/32/64-bit field starting at lane = offset.
  - Multi-byte fields SHALL be assembled in the configured endianness, the lowest-address lane being least significant when little-endian and most significant when big-endian.
  - The field SHALL then be sign- or zero-extended to DATA_W per LoadSigned_MEM.
REQ-015 Alignment rules for ResultSel=1:
  - Offset not a multiple of the access size SHALL be misaligned.
  - LoadSize=3 with DATA_W=32 SHALL be illegal.
  - LoadSize=2 with DATA_W=32 SHALL ignore LoadSigned_MEM.
REQ-016 Write_Data_WB SHALL load:
  - ResultSel 0: ALU_Result_MEM.
  - ResultSel 1: the extracted load.
  - ResultSel 2: PC_Plus8_MEM.
  - ResultSel 3: 0.
REQ-017 err_WB SHALL load 1 for a misaligned or illegal load, or for ResultSel=3; in these cases Write_Data_WB SHALL be 0 and RegWrite_WB SHALL be 0.
REQ-018 RegWrite_WB SHALL load RegWrite_MEM AND valid_MEM AND (WriteReg_MEM != 0) AND NOT error.
REQ-019 WriteReg_WB SHALL load WriteReg_MEM unchanged, including when writes are suppressed.
REQ-020 valid_WB SHALL load valid_MEM. An erroring instruction SHALL remain valid, so err_WB=1 together with valid_WB=1 identifies it.
REQ-021 No combinational path SHALL exist from any input to any output.

Reset
REQ-022 On reset=1 at a clk edge, all outputs SHALL become 0 irrespective of stall_i and flush_i.
REQ-023 On reset asserted mid-stall, the held instruction SHALL be discarded, and the first edge after release SHALL load normally.

Verification
REQ-024 Reset: assert reset with stall_i=1 and nonzero inputs -> all outputs 0 next edge.
REQ-025 LB signed, DATA_W=32, LE:
  - Stimulus: Read_Data=0x80123456, ALU_Result=0x00001003, WriteReg=8.
  - Response: Write_Data_WB=0xFFFFFF80, RegWrite_WB=1, err_WB=0.
REQ-026 LHU offset 2:
  - Stimulus: Read_Data=0xA1B2C3D4.
  - Response, LE: 0x0000A1B2.
  - Response, BIG_ENDIAN=1: 0x0000C3D4.
REQ-027 Misaligned LH:
  - Stimulus: ALU_Result=0x00000001, ResultSel=1, LoadSize=1.
  - Response: err_WB=1, RegWrite_WB=0, Write_Data_WB=0, valid_WB=1.
REQ-028 Hazard control:
  - Stimulus: load an ALU result 0x1234, then stall_i=1 for 3 cycles with changing inputs.
  - Response: outputs hold 0x1234.
  - Stimulus: then stall_i=1 and flush_i=1 together.
  - Response: valid_WB=0, RegWrite_WB=0.
REQ-029 Link and $zero:
  - Stimulus: ResultSel=2, PC_Plus8=0x00400008, WriteReg=31.
  - Response: Write_Data_WB=0x00400008, RegWrite_WB=1.
  - Stimulus: repeat with WriteReg=0.
  - Response: RegWrite_WB=0.
